freq_sweep_sequencer: RTL and testbench
=======================================

# freq_sweep_sequencer

Schedules reads from the frequency-selector ring buffer and turns them into a timed tone sequence on the device clock. On `start` it pulls `cfg_num_tones` 14-bit frequency words from the ring, holds each for a programmed dwell, and presents them to the downstream tone generator. It drives the ring's read enable and prefetches the next entry during each dwell, so consecutive tones are gapless. Sweeps run one-shot or continuous.

## Interface
- `FREQ_WIDTH`, 14, width of ring data and `tone_freq`.
- `COUNT_WIDTH`, 14, width of tone count and index.
- `DWELL_WIDTH`, 16, width of dwell-length config.
- `RD_LATENCY`, 1, ring read latency L in cycles (1..3), from `rd_en_ring` to valid `dout_ring`.
- `dev_clk`  in  1  sole clock; one clock for the whole block.
- `dev_rstn`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  single-cycle sweep request.
- `abort`  in  1  single-cycle sweep cancel.
- `cfg_num_tones`  in  COUNT_WIDTH  tones per pass, N.
- `cfg_dwell`  in  DWELL_WIDTH  cycles per tone.
- `cfg_repeat`  in  1  1 = loop passes until abort.
- `rd_en_ring`  out  1  ring read strobe, registered.
- `dout_ring`  in  FREQ_WIDTH  ring read data.
- `tone_freq`  out  FREQ_WIDTH  current tone word.
- `tone_valid`  out  1  high while a tone is being presented.
- `tone_strobe`  out  1  one-cycle pulse on the first cycle of each tone.
- `tone_index`  out  COUNT_WIDTH  position of the current tone within the pass, 0..N-1.
- `busy`  out  1  sweep in progress.
- `sweep_done`  out  1  one-cycle pulse at the end of each pass.

## Operation
- **Reset:** `dev_rstn` low forces all outputs, counters and the FSM to 0/IDLE immediately.
- **FSM states:** IDLE → FETCH → WAIT → DWELL.
- **IDLE → FETCH:** on `start`=1, `abort`=0 and `cfg_num_tones`≠0.
  - `cfg_num_tones`, `cfg_dwell` and `cfg_repeat` are latched at this point. Later config changes do not affect the running sweep.
- **FETCH:** one cycle with `rd_en_ring`=1.
- **WAIT:** L cycles. Capture `dout_ring` in the last WAIT cycle.
- **DWELL:** lasts D = max(`cfg_dwell`, L+1) cycles.
  - In its first cycle, issue the prefetch read (`rd_en_ring`=1) if another tone follows (index<N-1 or repeat). Capture the result into a prefetch register L cycles later.
  - When the dwell expires, load the prefetch register into `tone_freq` and start the next DWELL directly.
- **Index:** `tone_index` increments per tone and wraps N-1→0 in repeat mode. The ring wraps its own pointer; the sequencer never rewinds it.
- **Reads per pass:** exactly N ring reads. No read is issued after the last tone of a one-shot sweep.
- **End of one-shot pass:** in the cycle after the last dwell, `tone_valid`=0, `busy`=0 and `sweep_done`=1, then IDLE.
- **End of repeat pass:** `sweep_done` pulses in the same cycle as the index-0 strobe of the next pass. `busy` and `tone_valid` stay high.
- **`abort`:** wins over `start` and over every other event in the same cycle. On the next edge: IDLE, `tone_valid`=`busy`=0, no `sweep_done`, in-flight read data discarded. Ring entries already consumed are not restored.
- **Ignored `start`:** `start` is ignored while `busy`, and ignored when `cfg_num_tones`=0.
- **Dwell counter:** loads D-1 and counts down. Clamp logic is evaluated once, at start.

## Timing
- **First tone,** with `start` high in cycle c:
  - `rd_en_ring` high in c+1.
  - `dout_ring` sampled in c+1+L.
  - `tone_strobe`, `tone_valid` and the new `tone_freq` appear in c+2+L. This cycle is T0.
- **Tone k:** strobe at T0+k·D. Prefetch `rd_en_ring` coincides with each strobe.
- **One-shot end:** `sweep_done` at T0+N·D, with `busy` high from c+1 through T0+N·D-1.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **One-shot sweep:** L=1, N=3, `cfg_dwell`=4, repeat=0, ring holds 100, 200, 300; `start` at cycle 0.
  - `rd_en_ring` at cycles 1, 3, 7.
  - Strobes at 3/7/11 with freq 100/200/300 and index 0/1/2.
  - `sweep_done` and `tone_valid`=0 at 15; exactly 3 reads.
- **Dwell clamp:** L=2, `cfg_dwell`=0, N=2.
  - Each tone lasts 3 cycles; strobes 3 cycles apart; `tone_valid` continuous with no gap.
- **Repeat and abort:** repeat=1, N=2, dwell=5.
  - Index runs 0,1,0,1; `sweep_done` on each index-0 strobe after the first.
  - `abort` mid-dwell: `tone_valid`=`busy`=0 the next cycle, no `sweep_done`.
  - `start`+`abort` in the same cycle: stays IDLE.
- **Ignored start and config changes:**
  - `start` with `cfg_num_tones`=0: no `rd_en_ring`, `busy` stays 0.
  - `start` pulsed while busy: no effect.
  - `cfg_dwell` changed mid-sweep: the running dwell keeps its latched value.
- **Asynchronous reset:** `dev_rstn` low mid-dwell.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, a new `start` reproduces the first-tone timing of scenario 1.

Source files
------------

// File: rtl/freq_sweep_sequencer.sv
// freq_sweep_sequencer: reads N frequency words from a ring buffer and plays them as gapless timed tones
//   dev_clk/dev_rstn  : clock, async active-low reset
//   start/abort       : single-cycle sweep request / cancel (abort wins)
//   cfg_num_tones/cfg_dwell/cfg_repeat : tones per pass, cycles per tone, loop mode (latched at start)
//   rd_en_ring/dout_ring : ring read strobe (registered) and read data (RD_LATENCY cycles later)
//   tone_freq/tone_valid/tone_strobe/tone_index : current tone word, presence, first-cycle pulse, position
//   busy/sweep_done   : sweep in progress, end-of-pass pulse
module freq_sweep_sequencer #(
  parameter int FREQ_WIDTH  = 14,
  parameter int COUNT_WIDTH = 14,
  parameter int DWELL_WIDTH = 16,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   dev_clk,
  input  logic                   dev_rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] cfg_num_tones,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_repeat,
  output logic                   rd_en_ring,
  input  logic [FREQ_WIDTH-1:0]  dout_ring,
  output logic [FREQ_WIDTH-1:0]  tone_freq,
  output logic                   tone_valid,
  output logic                   tone_strobe,
  output logic [COUNT_WIDTH-1:0] tone_index,
  output logic                   busy,
  output logic                   sweep_done
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DWELL} state_t;
  localparam logic [DWELL_WIDTH-1:0] MIN_DWELL = DWELL_WIDTH'(RD_LATENCY + 1);
  state_t state_q, state_d;
  logic [COUNT_WIDTH-1:0] n_q, n_d, idx_q, idx_d, n_m1, idx_nxt;
  logic [DWELL_WIDTH-1:0] dwell_m1_q, dwell_m1_d, cnt_q, cnt_d;
  logic [FREQ_WIDTH-1:0]  freq_q, freq_d, pf_q, pf_d;
  logic [RD_LATENCY-1:0]  pipe_q, pipe_d;
  logic rep_q, rep_d, rd_en_q, rd_en_d, valid_q, valid_d, strobe_q, strobe_d;
  logic busy_q, busy_d, done_q, done_d;
  logic data_ok, last, more;
  assign n_m1    = n_q - 1'b1;
  assign last    = idx_q == n_m1;
  assign more    = !last || rep_q;
  assign idx_nxt = last ? '0 : idx_q + 1'b1;
  // pipe_q tracks issued reads; its top bit marks the cycle dout_ring holds the requested word
  assign data_ok = pipe_q[RD_LATENCY-1];
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    rep_d      = rep_q;
    dwell_m1_d = dwell_m1_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    freq_d     = freq_q;
    pf_d       = pf_q;
    pipe_d     = (pipe_q << 1) | RD_LATENCY'(rd_en_q);
    rd_en_d    = 1'b0;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (start && cfg_num_tones != '0) begin
        state_d    = FETCH;
        n_d        = cfg_num_tones;
        rep_d      = cfg_repeat;
        dwell_m1_d = (cfg_dwell < MIN_DWELL ? MIN_DWELL : cfg_dwell) - 1'b1;
        idx_d      = '0;
        rd_en_d    = 1'b1;
      end
      FETCH: state_d = WAIT;
      WAIT: if (data_ok) begin
        state_d  = DWELL;
        freq_d   = dout_ring;
        idx_d    = '0;
        cnt_d    = dwell_m1_q;
        strobe_d = 1'b1;
        rd_en_d  = n_q != 1 || rep_q;
      end
      DWELL: begin
        if (data_ok) pf_d = dout_ring;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (more) begin
          // shortest dwell lands the prefetch on the final cycle, so bypass the register
          freq_d   = data_ok ? dout_ring : pf_q;
          idx_d    = idx_nxt;
          cnt_d    = dwell_m1_q;
          strobe_d = 1'b1;
          done_d   = last;
          rd_en_d  = idx_nxt != n_m1 || rep_q;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    if (abort) begin
      state_d  = IDLE;
      pipe_d   = '0;
      rd_en_d  = 1'b0;
      strobe_d = 1'b0;
      done_d   = 1'b0;
    end
    busy_d  = state_d != IDLE;
    valid_d = state_d == DWELL;
  end
  always_ff @(posedge dev_clk or negedge dev_rstn)
    if (!dev_rstn) begin
      state_q    <= IDLE;
      n_q        <= '0;
      rep_q      <= 1'b0;
      dwell_m1_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      freq_q     <= '0;
      pf_q       <= '0;
      pipe_q     <= '0;
      rd_en_q    <= 1'b0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      rep_q      <= rep_d;
      dwell_m1_q <= dwell_m1_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      freq_q     <= freq_d;
      pf_q       <= pf_d;
      pipe_q     <= pipe_d;
      rd_en_q    <= rd_en_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  assign rd_en_ring  = rd_en_q;
  assign tone_freq   = freq_q;
  assign tone_valid  = valid_q;
  assign tone_strobe = strobe_q;
  assign tone_index  = idx_q;
  assign busy        = busy_q;
  assign sweep_done  = done_q;
endmodule

// File: tb/tb_freq_sweep_sequencer.sv
// tb_freq_sweep_sequencer: table, directed and random checks of two sequencers (ring latency 1 and 2)
module tb_freq_sweep_sequencer;
  localparam int NEVER = 1000000;
  logic dev_clk, dev_rstn, start, abort, cfg_repeat, ptr_clr;
  logic [13:0] cfg_num_tones;
  logic [15:0] cfg_dwell;
  logic rd_en [2];
  logic valid [2];
  logic strobe [2];
  logic busy [2];
  logic done [2];
  logic [13:0] dout [2];
  logic [13:0] freq [2];
  logic [13:0] idx [2];
  logic [13:0] mem [64];
  logic [13:0] dpipe [2][3];
  int ptr [2];
  int errors = 0, checks = 0;
  int m_n, m_dw, m_abort;
  bit m_rep;
  typedef struct packed {logic st; logic [4:0] ctl; logic [13:0] f, ix;} vec_t;
  vec_t vec [17];

  freq_sweep_sequencer #(.RD_LATENCY(1)) u_dut1 (
    .dev_clk(dev_clk), .dev_rstn(dev_rstn), .start(start), .abort(abort),
    .cfg_num_tones(cfg_num_tones), .cfg_dwell(cfg_dwell), .cfg_repeat(cfg_repeat),
    .rd_en_ring(rd_en[0]), .dout_ring(dout[0]), .tone_freq(freq[0]), .tone_valid(valid[0]),
    .tone_strobe(strobe[0]), .tone_index(idx[0]), .busy(busy[0]), .sweep_done(done[0]));
  freq_sweep_sequencer #(.RD_LATENCY(2)) u_dut2 (
    .dev_clk(dev_clk), .dev_rstn(dev_rstn), .start(start), .abort(abort),
    .cfg_num_tones(cfg_num_tones), .cfg_dwell(cfg_dwell), .cfg_repeat(cfg_repeat),
    .rd_en_ring(rd_en[1]), .dout_ring(dout[1]), .tone_freq(freq[1]), .tone_valid(valid[1]),
    .tone_strobe(strobe[1]), .tone_index(idx[1]), .busy(busy[1]), .sweep_done(done[1]));

  initial dev_clk = 0;
  always #5 dev_clk = ~dev_clk;

  // ring model: each read returns the next entry after the instance's latency; junk otherwise
  always @(posedge dev_clk)
    for (int j = 0; j < 2; j++) begin
      dpipe[j][0] <= rd_en[j] ? mem[ptr[j] % 64] : 14'($urandom);
      dpipe[j][1] <= dpipe[j][0];
      dpipe[j][2] <= dpipe[j][1];
      if (ptr_clr) ptr[j] <= 0;
      else if (rd_en[j]) ptr[j] <= ptr[j] + 1;
    end
  assign dout[0] = dpipe[0][0];
  assign dout[1] = dpipe[1][1];

  function automatic logic [32:0] get_obs(int j);
    return {rd_en[j], valid[j], strobe[j], busy[j], done[j],
            valid[j] ? freq[j] : 14'd0, valid[j] ? idx[j] : 14'd0};
  endfunction

  // expected outputs rel cycles after the start cycle, derived from tone arithmetic
  function automatic logic [32:0] model(int l, int rel);
    int d, t0, k, ph;
    logic rd = 0, v = 0, s = 0, b = 0, dn = 0;
    logic [13:0] f = 0, ix = 0;
    d  = (m_dw > l + 1) ? m_dw : l + 1;
    t0 = l + 2;
    if (rel >= 1 && rel <= m_abort) begin
      k  = rel >= t0 ? (rel - t0) / d : -1;
      ph = rel >= t0 ? (rel - t0) % d : 0;
      if (!m_rep && k >= m_n) dn = rel == t0 + m_n * d;
      else begin
        b  = 1;
        rd = rel == 1 || (k >= 0 && ph == 0 && (m_rep || k + 1 < m_n));
        if (k >= 0) begin
          v  = 1;
          s  = ph == 0;
          dn = s && k > 0 && k % m_n == 0;
          f  = mem[k % 64];
          ix = 14'(k % m_n);
        end
      end
    end
    return {rd, v, s, b, dn, f, ix};
  endfunction

  task automatic chk(string nm, logic [32:0] act, logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_ring();
    @(posedge dev_clk); #1 ptr_clr = 1;
    @(posedge dev_clk); #1 ptr_clr = 0;
  endtask

  task automatic run_table(string nm);
    clear_ring();
    mem[0] = 100; mem[1] = 200; mem[2] = 300;
    cfg_num_tones = 3; cfg_dwell = 4; cfg_repeat = 0;
    for (int i = 0; i < 17; i++) begin
      @(posedge dev_clk); #1;
      chk($sformatf("%s cyc%0d", nm, i), get_obs(0), {vec[i].ctl, vec[i].f, vec[i].ix});
      start = vec[i].st;
    end
    chk($sformatf("%s reads", nm), 33'(ptr[0]), 33'd3);
    repeat (8) @(posedge dev_clk);
  endtask

  task automatic run_sweep(int n, int dw, bit rep, int ab);
    int len;
    int exp_rd [2];
    logic [32:0] e1, e2;
    len = ab < NEVER ? ab + 4 : 6 + n * (dw > 3 ? dw : 3);
    for (int i = 0; i < 64; i++) mem[i] = 14'($urandom);
    clear_ring();
    m_n = n; m_dw = dw; m_rep = rep; m_abort = ab;
    exp_rd[0] = 0; exp_rd[1] = 0;
    for (int rel = 0; rel <= len; rel++) begin
      @(posedge dev_clk); #1;
      e1 = model(1, rel);
      e2 = model(2, rel);
      exp_rd[0] += int'(e1[32]);
      exp_rd[1] += int'(e2[32]);
      chk($sformatf("sweep n%0d d%0d r%0d L1 rel%0d", n, dw, rep, rel), get_obs(0), e1);
      chk($sformatf("sweep n%0d d%0d r%0d L2 rel%0d", n, dw, rep, rel), get_obs(1), e2);
      start = rel == 0 || (e1[29] && e2[29] && $urandom_range(0, 3) == 0);
      abort = rel == ab;
      if (rel == 0) begin
        cfg_num_tones = 14'(n); cfg_dwell = 16'(dw); cfg_repeat = rep;
      end else begin
        cfg_num_tones = 14'($urandom_range(0, 7));
        cfg_dwell = 16'($urandom_range(0, 9));
        cfg_repeat = 1'($urandom);
      end
    end
    start = 0; abort = 0;
    chk($sformatf("reads n%0d L1", n), 33'(ptr[0]), 33'(exp_rd[0]));
    chk($sformatf("reads n%0d L2", n), 33'(ptr[1]), 33'(exp_rd[1]));
  endtask

  task automatic idle_probe(string nm, bit ab, int n);
    @(posedge dev_clk); #1;
    start = 1; abort = ab; cfg_num_tones = 14'(n); cfg_dwell = 4; cfg_repeat = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge dev_clk); #1;
      start = 0; abort = 0;
      for (int j = 0; j < 2; j++) chk($sformatf("%s L%0d cyc%0d", nm, j + 1, i), get_obs(j), 33'd0);
    end
  endtask

  initial begin
    vec[0]  = '{1, 5'b00000, 14'd0,   14'd0};
    vec[1]  = '{0, 5'b10010, 14'd0,   14'd0};
    vec[2]  = '{0, 5'b00010, 14'd0,   14'd0};
    vec[3]  = '{0, 5'b11110, 14'd100, 14'd0};
    vec[4]  = '{0, 5'b01010, 14'd100, 14'd0};
    vec[5]  = '{0, 5'b01010, 14'd100, 14'd0};
    vec[6]  = '{0, 5'b01010, 14'd100, 14'd0};
    vec[7]  = '{0, 5'b11110, 14'd200, 14'd1};
    vec[8]  = '{0, 5'b01010, 14'd200, 14'd1};
    vec[9]  = '{0, 5'b01010, 14'd200, 14'd1};
    vec[10] = '{0, 5'b01010, 14'd200, 14'd1};
    vec[11] = '{0, 5'b01110, 14'd300, 14'd2};
    vec[12] = '{0, 5'b01010, 14'd300, 14'd2};
    vec[13] = '{0, 5'b01010, 14'd300, 14'd2};
    vec[14] = '{0, 5'b01010, 14'd300, 14'd2};
    vec[15] = '{0, 5'b00001, 14'd0,   14'd0};
    vec[16] = '{0, 5'b00000, 14'd0,   14'd0};
    for (int i = 0; i < 64; i++) mem[i] = 14'($urandom);
    dev_rstn = 0; start = 0; abort = 0; ptr_clr = 0;
    cfg_num_tones = 0; cfg_dwell = 0; cfg_repeat = 0;
    repeat (2) @(posedge dev_clk);
    #1;
    for (int j = 0; j < 2; j++) chk($sformatf("reset L%0d", j + 1), get_obs(j), 33'd0);
    dev_rstn = 1;
    run_table("oneshot");
    run_sweep(2, 0, 0, NEVER);
    run_sweep(2, 5, 1, 30);
    run_sweep(3, 4, 0, 9);
    idle_probe("start_abort", 1, 3);
    idle_probe("zero_tones", 0, 0);
    for (int t = 0; t < 12; t++) begin
      int n, dw, ab;
      bit rep;
      n = $urandom_range(1, 4);
      dw = $urandom_range(0, 6);
      rep = 1'($urandom);
      ab = rep ? $urandom_range(2, 25) : ($urandom_range(0, 2) == 0 ? $urandom_range(1, 20) : NEVER);
      run_sweep(n, dw, rep, ab);
    end
    clear_ring();
    @(posedge dev_clk); #1;
    start = 1; cfg_num_tones = 3; cfg_dwell = 4; cfg_repeat = 0;
    @(posedge dev_clk); #1 start = 0;
    repeat (5) @(posedge dev_clk);
    #3 dev_rstn = 0;
    #1;
    for (int j = 0; j < 2; j++) chk($sformatf("async_reset L%0d", j + 1), get_obs(j), 33'd0);
    @(posedge dev_clk); #1;
    for (int j = 0; j < 2; j++) chk($sformatf("held_reset L%0d", j + 1), get_obs(j), 33'd0);
    dev_rstn = 1;
    run_table("after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
